// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file with write bypass, pending scoreboard and clear sweep
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     EN,
  input  logic [ADDR_W-1:0]        WA,
  input  logic [DATA_W-1:0]        WD,
  input  logic                     ISSUE,
  input  logic [ADDR_W-1:0]        ISSUE_ADR,
  input  logic [NUM_RD*ADDR_W-1:0] ADR,
  output logic [NUM_RD*DATA_W-1:0] RS,
  output logic [NUM_RD-1:0]        RDY,
  input  logic                     CLR,
  output logic                     BUSY
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              wr_ok;
  logic              iss_ok;

  assign wr_ok  = EN    && (state == IDLE) && !(ZERO_REG && (WA == '0));
  assign iss_ok = ISSUE && (state == IDLE) && !(ZERO_REG && (ISSUE_ADR == '0));
  assign BUSY   = (state == SWEEP);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CLR) state_nxt = SWEEP;
      SWEEP:   if (cnt == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue is applied after the write so a same-address collision leaves the entry pending.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs[k] <= '0;
      end
      pend <= '0;
    end else if (state == SWEEP) begin
      regs[cnt] <= '0;
      pend[cnt] <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[WA] <= WD;
        pend[WA] <= 1'b0;
      end
      if (iss_ok) begin
        pend[ISSUE_ADR] <= 1'b1;
      end
    end
  end

  always_comb begin
    RS  = '0;
    RDY = '0;
    if (state == IDLE) begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (ZERO_REG && (ADR[i*ADDR_W +: ADDR_W] == '0)) begin
          RS[i*DATA_W +: DATA_W] = '0;
          RDY[i]                 = 1'b1;
        end else if (EN && (WA == ADR[i*ADDR_W +: ADDR_W])) begin
          RS[i*DATA_W +: DATA_W] = WD;
          RDY[i]                 = 1'b1;
        end else begin
          RS[i*DATA_W +: DATA_W] = regs[ADR[i*ADDR_W +: ADDR_W]];
          RDY[i]                 = ~pend[ADR[i*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file for the next OTTER pipelined core.
- Generalises the single-cycle 32x32, 2-read-port file in width, depth and read-port count.
- Adds posedge write with same-cycle read bypass, a per-register pending-write scoreboard for hazard detection, and a sequential clear sweep.
- Sits between decode (reads, issue marking) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; must be a power of 2, at least 2
- ADDR_W, $clog2(DEPTH), address width (derived)
- NUM_RD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1 = register 0 is hardwired zero and never pending

Ports:
- CLK  in  1  clock; all state changes on posedge
- RST_N  in  1  asynchronous active-low reset
- EN  in  1  write enable
- WA  in  ADDR_W  write address
- WD  in  DATA_W  write data
- ISSUE  in  1  mark destination register pending
- ISSUE_ADR  in  ADDR_W  destination address to mark
- ADR  in  NUM_RD*ADDR_W  read addresses; port i = ADR[i*ADDR_W +: ADDR_W]
- RS  out  NUM_RD*DATA_W  read data; port i = RS[i*DATA_W +: DATA_W]
- RDY  out  NUM_RD  port i operand is valid (not pending)
- CLR  in  1  request clear sweep
- BUSY  out  1  sweep in progress

Behaviour:
- Reset (RST_N=0, asynchronous):
  - all registers = 0, all pending bits = 0, FSM = IDLE, sweep counter = 0.
  - Outputs: BUSY=0; RS = 0 for every port; RDY = all ones.
  - Reset asserted mid-sweep aborts to IDLE; the array is still fully cleared by reset.
- Write: at posedge, if EN=1 and FSM=IDLE and not (ZERO_REG=1 and WA=0), then REG[WA] <= WD and pend[WA] <= 0.
- Issue: at posedge, if ISSUE=1 and FSM=IDLE and not (ZERO_REG=1 and ISSUE_ADR=0), then pend[ISSUE_ADR] <= 1.
  - Same cycle, same address as a write: data is written and pend ends at 1 (issue wins; a new producer is in flight).
- Read, combinational, for each port i with a = ADR slice i:
  - if ZERO_REG=1 and a=0: RS_i = 0, RDY_i = 1;
  - else if EN=1 and WA=a: RS_i = WD (bypass), RDY_i = 1;
  - else RS_i = REG[a], RDY_i = ~pend[a].
  - A write-port bypass applies to all read ports at once; no read-port count limit.
- FSM states IDLE and SWEEP:
  - IDLE -> SWEEP when CLR=1; counter <= 0.
  - In SWEEP, each cycle REG[counter] <= 0, pend[counter] <= 0, counter increments.
  - When counter = DEPTH-1, the last entry is cleared and the FSM returns to IDLE.
  - BUSY=1 exactly DEPTH cycles, starting the cycle after CLR is sampled.
  - During SWEEP: EN, ISSUE and CLR are ignored; RS = 0 and RDY = 0 on all ports.
  - CLR held high in IDLE after a sweep completes starts a new sweep.
  - The counter wraps naturally at DEPTH; no out-of-range access.
- No X propagation: all outputs are defined for all addresses when DEPTH = 2^ADDR_W.

Test Plan:
- Reset then write: RST_N low then high; EN=1, WA=5, WD=32'hDEADBEEF; next cycle ADR0=5 -> RS0=32'hDEADBEEF, RDY0=1; ADR1=0 -> RS1=0.
- x0 protection: EN=1, WA=0, WD=32'h1234 and ISSUE=1, ISSUE_ADR=0; then read ADR0=0 -> RS0=0, RDY0=1.
- Bypass and scoreboard: ISSUE with ISSUE_ADR=7, then ADR0=7 -> RDY0=0. Next, EN=1, WA=7, WD=32'hA5A5A5A5 in the same cycle as ADR0=7 -> RS0=32'hA5A5A5A5, RDY0=1 that cycle; after the edge RDY0 stays 1.
- Issue/write collision: EN=1, WA=9 and ISSUE=1, ISSUE_ADR=9 in the same cycle, WD=32'h11 -> after the edge RS(9)=32'h11, RDY=0.
- Clear sweep: fill regs 1..31 with nonzero values and pend reg 3; pulse CLR -> BUSY=1 for exactly 32 cycles, a write attempted mid-sweep has no effect; afterwards all reads = 0 and RDY all 1.
- Reset mid-sweep with NUM_RD=4, DEPTH=16: assert RST_N=0 at sweep cycle 6 -> BUSY=0 immediately, all 4 ports read 0 with RDY=1, and a new CLR restarts the sweep at counter 0.
